// File: rtl/piso_shift_transmitter.sv
// ---------------------------------------------------------------------------
// piso_shift_transmitter
//   Parallel-in / serial-out transmitter. A word is captured on a
//   load_valid/load_ready handshake and shifted out one bit per clock while
//   shift_en is high. A stalled stream (shift_en low) freezes every output.
//
// Handshake: a word is accepted on a rising edge where load_valid and
//   load_ready are both 1. load_ready is 1 in IDLE, and in SHIFT only on the
//   final bit while shift_en is 1. This lets a new word follow the previous
//   one without a gap. load_valid may be held while load_ready is 0; din is
//   ignored until the handshake completes.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-low reset
//   din        in   [WIDTH-1:0] parallel word, sampled on accept
//   load_valid in   producer offers din
//   load_ready out  block can accept a word this cycle
//   shift_en   in   advance permission (0 stalls the stream)
//   dout       out  registered serial data
//   dout_valid out  dout carries a valid bit
//   dout_last  out  dout carries the final bit of the word
//   busy       out  state is SHIFT
//   dbg_state  out  raw FSM state (0 = IDLE, 1 = SHIFT) for checkers
// ---------------------------------------------------------------------------
module piso_shift_transmitter #(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy,
  output logic             dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(WIDTH - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_last_q, dout_last_d;
  logic             accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sr_q         <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
    end
  end

  // Ready only on the final bit while it is actually advancing, so a new
  // word can take the slot that bit vacates on the same edge.
  always_comb begin
    load_ready = 1'b0;
    if (state_q == IDLE) begin
      load_ready = 1'b1;
    end else if ((cnt_q == CNT_LAST) && shift_en) begin
      load_ready = 1'b1;
    end
  end

  assign accept = load_valid && load_ready;

  // sr_q always holds the word with the bit currently on dout at the
  // outgoing end (bit 0 for LSB-first, bit WIDTH-1 for MSB-first), so the
  // next bit to present is always the neighbour of that end.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;

    if (accept) begin
      state_d      = SHIFT;
      cnt_d        = '0;
      sr_d         = din;
      dout_d       = (LSB_FIRST != 0) ? din[0] : din[WIDTH-1];
      dout_valid_d = 1'b1;
      dout_last_d  = 1'b0;
    end else if ((state_q == SHIFT) && shift_en) begin
      if (cnt_q == CNT_LAST) begin
        state_d      = IDLE;
        cnt_d        = '0;
        sr_d         = '0;
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
      end else begin
        cnt_d        = cnt_q + CNT_W'(1);
        sr_d         = (LSB_FIRST != 0) ? (sr_q >> 1) : (sr_q << 1);
        dout_d       = (LSB_FIRST != 0) ? sr_q[1] : sr_q[WIDTH-2];
        dout_valid_d = 1'b1;
        dout_last_d  = (cnt_q == CNT_PRELAST);
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign busy       = (state_q == SHIFT);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// ---------------------------------------------------------------------------
// Bench for piso_shift_transmitter. Two instances (LSB-first and MSB-first)
// share every input; only their dout differs. A queue-of-bits reference
// model predicts the outputs of both each cycle.
// ---------------------------------------------------------------------------
module tb_piso_shift_transmitter;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;
  logic         shift_en = 1'b0;

  logic l_ready, l_dout, l_valid, l_last, l_busy, l_dbg;
  logic m_ready, m_dout, m_valid, m_last, m_busy, m_dbg;

  piso_shift_transmitter #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(l_ready), .shift_en(shift_en), .dout(l_dout),
    .dout_valid(l_valid), .dout_last(l_last), .busy(l_busy),
    .dbg_state(l_dbg)
  );

  piso_shift_transmitter #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(m_ready), .shift_en(shift_en), .dout(m_dout),
    .dout_valid(m_valid), .dout_last(m_last), .busy(m_busy),
    .dbg_state(m_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining bits of the word in flight, in transmit
  // order. Front of the queue is what dout shows now.
  logic ql[$];
  logic qm[$];

  function automatic logic [9:0] model_out(input logic se);
    logic v, l, r, dl, dm;
    v  = (ql.size() > 0);
    l  = (ql.size() == 1);
    r  = (ql.size() == 0) || ((ql.size() == 1) && se);
    dl = v ? ql[0] : 1'b0;
    dm = v ? qm[0] : 1'b0;
    return {dl, v, l, v, r, dm, v, l, v, r};
  endfunction

  task automatic model_edge(input logic lv, input logic [W-1:0] d, input logic se);
    logic r;
    r = (ql.size() == 0) || ((ql.size() == 1) && se);
    if (lv && r) begin
      ql.delete();
      qm.delete();
      for (int i = 0; i < W; i++) begin
        ql.push_back(d[i]);
        qm.push_back(d[W-1-i]);
      end
    end else if ((ql.size() > 0) && se) begin
      void'(ql.pop_front());
      void'(qm.pop_front());
    end
  endtask

  function automatic logic [9:0] dut_out();
    return {l_dout, l_valid, l_last, l_busy, l_ready,
            m_dout, m_valid, m_last, m_busy, m_ready};
  endfunction

  // Samples from the most recent step, for scenario-level checks.
  logic s_dout_l, s_valid, s_ready;

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic lv, input logic [W-1:0] d, input logic se,
                      input logic has_exp, input logic [9:0] exp);
    load_valid = lv;
    din        = d;
    shift_en   = se;
    #1;
    s_dout_l = l_dout;
    s_valid  = l_valid;
    s_ready  = l_ready;
    chk("model_outputs", 32'(dut_out()), 32'(model_out(se)));
    if (has_exp) chk("table_outputs", 32'(dut_out()), 32'(exp));
    @(posedge clk);
    model_edge(lv, d, se);
    @(negedge clk);
  endtask

  task automatic run(input logic lv, input logic [W-1:0] d, input logic se);
    step(lv, d, se, 1'b0, 10'd0);
  endtask

  // Reset pulse inside the low clock phase: no edge occurs while it is low.
  task automatic reset_pulse();
    load_valid = 1'b0;
    shift_en   = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("reset_async_outputs", 32'(dut_out()), 32'(10'b0000100001));
    ql.delete();
    qm.delete();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic         lv;
    logic [W-1:0] d;
    logic         se;
    logic         dl;
    logic         dm;
    logic         v;
    logic         l;
    logic         r;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic lv, input logic [W-1:0] d, input logic se,
                              input logic dl, input logic dm, input logic v,
                              input logic l, input logic r);
    vec_t t;
    t.lv = lv; t.d = d; t.se = se; t.dl = dl; t.dm = dm; t.v = v; t.l = l; t.r = r;
    return t;
  endfunction

  initial begin
    logic [6:0] seq7;
    logic [3:0] seq4;
    int         nvalid;
    bit         saw_f;

    // 1011 LSB: 1,1,0,1  MSB: 1,0,1,1
    tbl[0]  = mk(1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[1]  = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    // idle again, accept A; then A (LSB 0,1,0,1 / MSB 1,0,1,0) and 5 gapless
    tbl[5]  = mk(1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[10] = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tbl[14] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state, held across a rising edge.
    #1;
    chk("reset_state", 32'(dut_out()), 32'(10'b0000100001));
    chk("reset_dbg_state", 32'({l_dbg, m_dbg}), 32'(2'b00));
    @(negedge clk);
    chk("reset_state_after_edge", 32'(dut_out()), 32'(10'b0000100001));
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].lv, tbl[i].d, tbl[i].se, 1'b1,
           {tbl[i].dl, tbl[i].v, tbl[i].l, tbl[i].v, tbl[i].r,
            tbl[i].dm, tbl[i].v, tbl[i].l, tbl[i].v, tbl[i].r});
    end

    // Stall after bit 1 of 1011: dout 1 x5 (bit 0, then bit 1 held 4 cycles), 0, 1.
    run(1'b1, 4'hB, 1'b0);  // accept with shift_en low in IDLE
    seq7 = '0; nvalid = 0;
    for (int i = 0; i < 9; i++) begin
      logic se;
      se = !(i >= 1 && i <= 3);
      run(1'b0, 4'h0, se);
      if (s_valid) begin
        if (nvalid < 7) seq7[6-nvalid] = s_dout_l;
        nvalid++;
        if (nvalid < 7) chk("stall_ready_low", 32'(s_ready), 32'(0));
      end
    end
    chk("stall_valid_cycles", 32'(nvalid), 32'(7));
    chk("stall_sequence", 32'(seq7), 32'(7'b1111101));

    // Offered word while busy is ignored: 6 (LSB 0,1,1,0), F offered mid-word.
    run(1'b1, 4'h6, 1'b1);
    seq4 = '0; nvalid = 0; saw_f = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run((i < 3) ? 1'b1 : 1'b0, 4'hF, 1'b1);
      if (s_valid) begin
        if (nvalid < 4) seq4[3-nvalid] = s_dout_l;
        nvalid++;
      end
    end
    chk("flood_valid_cycles", 32'(nvalid), 32'(4));
    chk("flood_sequence", 32'(seq4), 32'(4'b0110));

    // Reset mid-word after bit 2, then a clean word 1001.
    run(1'b1, 4'hB, 1'b1);
    run(1'b0, 4'h0, 1'b1);
    run(1'b0, 4'h0, 1'b1);
    chk("pre_reset_busy", 32'({l_busy, l_valid}), 32'(2'b11));
    reset_pulse();
    seq4 = '0; nvalid = 0;
    run(1'b1, 4'h9, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run(1'b0, 4'h0, 1'b1);
      if (s_valid) begin
        if (nvalid < 4) seq4[3-nvalid] = s_dout_l;
        nvalid++;
      end
    end
    chk("post_reset_valid_cycles", 32'(nvalid), 32'(4));
    chk("post_reset_sequence", 32'(seq4), 32'(4'b1001));

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset_pulse();
      end else begin
        run(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_shift_transmitter.md
PISO_SHIFT_TRANSMITTER -- requirements
Module: piso_shift_transmitter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: number of bits per word, legal range 2..32.
REQ-002 The block SHALL have parameter LSB_FIRST, default 1: 1 = bit 0 is shifted out first, 0 = bit WIDTH-1 is shifted out first.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port din  input  WIDTH  parallel word to transmit, sampled on accept.
REQ-006 The block SHALL have port load_valid  input  1  producer offers din this cycle.
REQ-007 The block SHALL have port load_ready  output  1  block can accept a word this cycle (combinational from state, cnt and shift_en).
REQ-008 The block SHALL have port shift_en  input  1  advance permission; 0 stalls the serial stream.
REQ-009 The block SHALL have port dout  output  1  serial data, registered.
REQ-010 The block SHALL have port dout_valid  output  1  dout carries a valid bit this cycle.
REQ-011 The block SHALL have port dout_last  output  1  dout carries the final bit of the word.
REQ-012 The block SHALL have port busy  output  1  high whenever state is SHIFT.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE, SHIFT.
REQ-014 The block SHALL treat a word as accepted on a rising edge where load_valid=1 and load_ready=1.
REQ-015 The block SHALL drive load_ready=1 in IDLE, and in SHIFT only when cnt=WIDTH-1 and shift_en=1; otherwise load_ready=0.
REQ-016 On accept, the block SHALL capture din into the shift register, set cnt=0, enter SHIFT, and present the first bit on dout in the next cycle (latency 1 clock).
REQ-017 In SHIFT with shift_en=1, the block SHALL advance one bit per clock: right shift when LSB_FIRST=1, left shift when LSB_FIRST=0; cnt increments.
REQ-018 In SHIFT with shift_en=0, the block SHALL hold the shift register, cnt, dout, dout_valid and dout_last unchanged.
REQ-019 The block SHALL assert dout_valid=1 and busy=1 for exactly the cycles in SHIFT: WIDTH cycles when there is no stall.
REQ-020 The block SHALL assert dout_last=1 only while cnt=WIDTH-1 in SHIFT.
REQ-021 When the last bit advances (cnt=WIDTH-1, shift_en=1) without an accept, the block SHALL return to IDLE with dout=0, dout_valid=0, dout_last=0.
REQ-022 When the last bit advances and an accept occurs on the same edge, the block SHALL load the new word and remain in SHIFT, giving a gapless back-to-back stream.
REQ-023 When load_valid=1 and load_ready=0, the block SHALL ignore din and not corrupt the word in flight.
REQ-024 In IDLE, the block SHALL hold dout=0 regardless of shift_en.
REQ-025 When shift_en=0 in IDLE, the block SHALL still accept a word, with the first bit valid on the next cycle.

Reset
REQ-026 On rst=0, the block SHALL immediately (asynchronously) force state=IDLE, cnt=0, shift register=0, dout=0, dout_valid=0, dout_last=0 and busy=0.
REQ-027 With rst=0, the block SHALL drive load_ready=1, since state=IDLE.
REQ-028 When reset asserts mid-word, the block SHALL discard the word and not resume it after reset release.
REQ-029 After rst deasserts, the block SHALL accept a word on the first rising edge with load_valid=1.

Verification
REQ-030 Scenario: WIDTH=4, LSB_FIRST=1, shift_en=1, accept din=4'b1011 -> dout=1,1,0,1 on cycles 1-4, dout_last on cycle 4, busy=0 on cycle 5.
REQ-031 Scenario: LSB_FIRST=0, din=4'b1011 -> dout=1,0,1,1; dout_valid high for exactly 4 cycles.
REQ-032 Scenario: back-to-back accept of 4'hA then 4'h5 (LSB_FIRST=1), with the second accept on the dout_last cycle -> dout=0,1,0,1,1,0,1,0 with no dout_valid gap.
REQ-033 Scenario: shift_en low for 3 cycles after bit 1 of 4'b1011 -> dout holds 1 for 4 cycles, then 0,1 follow; total 7 valid cycles; load_ready=0 throughout.
REQ-034 Scenario: load_valid=1 with din=4'hF while busy (not last bit) -> in-flight word unchanged and 4'hF never appears.
REQ-035 Scenario: rst pulsed low after bit 2 -> dout, dout_valid, dout_last and busy go 0 without a clock edge; load_ready=1; the next accepted word transmits cleanly.
